pcm_mixer_n: RTL and testbench
==============================

# pcm_mixer_n

Parametrised N-channel PCM audio mixer for arcade cores. It sits between the core's sound generators and the framework's signed 16-bit audio outputs, and replaces fixed two-channel averaging. Each channel has a hold register, a gain and a pan. Channels are accumulated sequentially, one per clock, on each output-sample tick. The result is saturated and delivered as a registered signed stereo pair with a one-cycle valid strobe.

## Interface
- G_CHANNELS, default 2: number of input channels, 1..8.
- G_IN_WIDTH, default 8: unsigned input sample width; midpoint 2^(G_IN_WIDTH-1) is silence.
- G_GAIN_WIDTH, default 4: unsigned gain width; unity gain is 2^(G_GAIN_WIDTH-1).
- G_OUT_WIDTH, default 16: signed output width; must be ≥ G_IN_WIDTH.
- clk_sys_i  in  1  core clock; all logic is on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- tick_i  in  1  output-sample strobe, one cycle wide.
- ch_data_i  in  G_CHANNELS*G_IN_WIDTH  channel k occupies bits [k*W +: W].
- ch_valid_i  in  G_CHANNELS  a high bit k loads ch_data_i slice k into hold k.
- ch_gain_i  in  G_CHANNELS*G_GAIN_WIDTH  per-channel gain.
- ch_pan_i  in  G_CHANNELS  0 = left, 1 = right; used in stereo mode only.
- stereo_i  in  1  0 = mono (every channel feeds both outputs), 1 = panned.
- mute_i  in  1  forces outputs to 0.
- audio_left_o, audio_right_o  out  G_OUT_WIDTH  signed mixed samples, registered.
- audio_valid_o  out  1  one-cycle pulse when the outputs update.
- busy_o  out  1  high while a mix is in progress.
- overrun_o  out  1  sticky flag; a tick arrived while busy.

## Operation
- Hold registers:
  - Hold k reloads on every edge where ch_valid_i[k]=1, in any FSM state.
  - Hold value is midpoint at reset.
- FSM states are IDLE, ACC and OUT.
- IDLE:
  - tick_i=1 snapshots all holds (pre-edge values), gains, pans, stereo_i and mute_i.
  - The same edge clears both accumulators, sets idx=0 and moves to ACC.
- ACC: one channel per edge.
  - s = hold_snap[idx] - 2^(W-1), signed W bits.
  - p = s * gain_snap[idx], signed.
  - acc_L += p if mono or pan=0.
  - acc_R += p if mono or pan=1.
  - When idx = G_CHANNELS-1, move to OUT; otherwise idx+1.
- Accumulator width is G_IN_WIDTH + G_GAIN_WIDTH + ceil(log2(G_CHANNELS)) + 1. Accumulators never overflow.
- OUT, for each side:
  - y = (acc << (G_OUT_WIDTH - G_IN_WIDTH)) >>> (G_GAIN_WIDTH-1), arithmetic shift rounding toward -inf.
  - Saturate y to [-2^(O-1), 2^(O-1)-1].
  - If mute_snap=1, load 0 instead of y.
  - Load the outputs, pulse audio_valid_o and return to IDLE.
- No averaging is applied: unity gain on a full-scale channel yields near full-scale output, and sums clip by saturation.
- tick_i while busy: the tick is ignored, the mix in progress is unaffected, and overrun_o is set. overrun_o clears only on reset.
- Input changes during a mix do not affect that mix: ch_valid updates hold registers only, and gain, pan, stereo and mute changes are not sampled until the next snapshot.

## Timing
- Reset values:
  - audio_left_o = audio_right_o = 0.
  - audio_valid_o = busy_o = overrun_o = 0.
  - State is IDLE and holds are at midpoint.
- Let edge T be the edge that samples tick_i=1 in IDLE.
- busy_o is high after edge T. It is low after edge T+G_CHANNELS+1.
- Outputs and audio_valid_o change at edge T+G_CHANNELS+1. The latency is G_CHANNELS+1 edges, and audio_valid_o is high for exactly one cycle.
- The minimum tick spacing without overrun is G_CHANNELS+2 cycles.
- tick_i arriving in the same cycle as the OUT state counts as busy and sets overrun.
- Reset asserted mid-mix immediately returns all state to reset values, with no valid pulse.
- Outputs hold their last value between mixes.

## Test plan
All scenarios use default parameters.
- Reset, then tick with no ch_valid -> after 3 edges audio_valid_o=1 for one cycle and L=R=0.
- Mono, gains 8/8:
  - ch0=0xFF, ch1=0x80 -> L=R=32512.
  - Both channels 0xFF -> L=R=32767 (saturated).
  - Both channels 0x00 -> L=R=-32768.
- Stereo, ch0=0xC0 pan0 gain8, ch1=0x40 pan1 gain4 -> L=16384, R=-8192.
- Gain 0 on both channels with data 0xFF -> 0. mute_i=1 with data 0xFF at gain 8 -> 0.
- Timing and overrun:
  - Tick at cycle 0, second tick at cycle 1 -> single valid pulse at edge 3 and overrun_o=1.
  - Tick at cycle 4 -> valid again and overrun stays 1.
- Data update during a mix:
  - ch_valid on the tick edge carrying 0xFF, with an old hold of 0x80 -> the current mix uses 0x80 and the next mix uses 0xFF.
  - Reset asserted during ACC -> outputs 0 and no valid pulse.

Source files
------------

// File: rtl/pcm_mixer_n.sv
// pcm_mixer_n: N-channel PCM mixer, per-channel gain/pan, one channel per clock, saturated stereo out
//   clk_sys_i/reset_i : clock, async active-high reset
//   tick_i            : output-sample strobe, starts a mix when idle
//   ch_*_i            : packed per-channel data, load strobes, gains, pans
//   stereo_i, mute_i  : panned vs mono mixing, force-zero output
//   audio_*_o         : registered signed stereo pair, valid pulse
//   busy_o, overrun_o : mix in progress, sticky "tick while busy"
module pcm_mixer_n #(
  parameter int G_CHANNELS   = 2,
  parameter int G_IN_WIDTH   = 8,
  parameter int G_GAIN_WIDTH = 4,
  parameter int G_OUT_WIDTH  = 16
) (
  input  logic                                 clk_sys_i,
  input  logic                                 reset_i,
  input  logic                                 tick_i,
  input  logic [G_CHANNELS*G_IN_WIDTH-1:0]     ch_data_i,
  input  logic [G_CHANNELS-1:0]                ch_valid_i,
  input  logic [G_CHANNELS*G_GAIN_WIDTH-1:0]   ch_gain_i,
  input  logic [G_CHANNELS-1:0]                ch_pan_i,
  input  logic                                 stereo_i,
  input  logic                                 mute_i,
  output logic signed [G_OUT_WIDTH-1:0]        audio_left_o,
  output logic signed [G_OUT_WIDTH-1:0]        audio_right_o,
  output logic                                 audio_valid_o,
  output logic                                 busy_o,
  output logic                                 overrun_o
);
  localparam int N  = G_CHANNELS;
  localparam int W  = G_IN_WIDTH;
  localparam int GW = G_GAIN_WIDTH;
  localparam int O  = G_OUT_WIDTH;
  localparam int AW = W + GW + $clog2(N) + 1;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int YW = AW + O - W;
  localparam logic signed [YW-1:0] HI = {{(YW-O+1){1'b0}}, {(O-1){1'b1}}};
  localparam logic signed [YW-1:0] LO = {{(YW-O+1){1'b1}}, {(O-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t state, state_nx;
  logic [N*W-1:0] hold, hold_snap;
  logic [N*GW-1:0] gain_snap;
  logic [N-1:0] pan_snap;
  logic stereo_snap, mute_snap;
  logic [IW-1:0] idx;
  logic signed [AW-1:0] acc_l, acc_r, pe;
  logic [W-1:0] h;
  logic [GW-1:0] g;
  logic signed [W+GW:0] p;
  logic to_l, to_r;
  // Scale accumulator to output width, drop the unity-gain bits (floor), then clip
  function automatic logic signed [O-1:0] scale(input logic signed [AW-1:0] a);
    logic signed [YW-1:0] y;
    y = a;
    y = (y <<< (O - W)) >>> (GW - 1);
    return y > HI ? HI[O-1:0] : y < LO ? LO[O-1:0] : y[O-1:0];
  endfunction
  always_comb begin
    h = hold_snap[idx*W +: W];
    g = gain_snap[idx*GW +: GW];
    // Flipping the MSB of an offset-binary sample gives its two's-complement value
    p = $signed({~h[W-1], h[W-2:0]}) * $signed({1'b0, g});
    pe = AW'(p);
    to_l = !stereo_snap || !pan_snap[idx];
    to_r = !stereo_snap || pan_snap[idx];
    state_nx = state == IDLE ? (tick_i ? ACC : IDLE)
             : state == ACC  ? (idx == IW'(N - 1) ? OUT : ACC)
             : IDLE;
  end
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_sys_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_sys_i or posedge reset_i)
    if (reset_i) begin
      hold <= {N{{1'b1, {(W-1){1'b0}}}}};
      hold_snap <= '0;
      gain_snap <= '0;
      pan_snap <= '0;
      stereo_snap <= 1'b0;
      mute_snap <= 1'b0;
      idx <= '0;
      acc_l <= '0;
      acc_r <= '0;
      audio_left_o <= '0;
      audio_right_o <= '0;
      audio_valid_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++)
        if (ch_valid_i[k]) hold[k*W +: W] <= ch_data_i[k*W +: W];
      overrun_o <= overrun_o || (tick_i && state != IDLE);
      audio_valid_o <= state == OUT;
      if (state == IDLE && tick_i) begin
        hold_snap <= hold;
        gain_snap <= ch_gain_i;
        pan_snap <= ch_pan_i;
        stereo_snap <= stereo_i;
        mute_snap <= mute_i;
        idx <= '0;
        acc_l <= '0;
        acc_r <= '0;
      end
      if (state == ACC) begin
        acc_l <= acc_l + (to_l ? pe : '0);
        acc_r <= acc_r + (to_r ? pe : '0);
        idx <= idx + 1'b1;
      end
      if (state == OUT) begin
        audio_left_o <= mute_snap ? '0 : scale(acc_l);
        audio_right_o <= mute_snap ? '0 : scale(acc_r);
      end
    end
endmodule

// File: tb/tb_pcm_mixer_n.sv
// tb_pcm_mixer_n: scoreboard bench for pcm_mixer_n at default parameters
module tb_pcm_mixer_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic stereo = 1'b0;
  logic mute = 1'b0;
  logic [15:0] data = 16'h8080;
  logic [1:0] vld = 2'b00;
  logic [1:0] pan = 2'b00;
  logic [7:0] gain = 8'h88;
  logic signed [15:0] left, right;
  logic valid, busy, overrun;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  typedef struct {int l; int r; int e;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pcm_mixer_n dut (
    .clk_sys_i(clk), .reset_i(rst), .tick_i(tick), .ch_data_i(data),
    .ch_valid_i(vld), .ch_gain_i(gain), .ch_pan_i(pan), .stereo_i(stereo),
    .mute_i(mute), .audio_left_o(left), .audio_right_o(right),
    .audio_valid_o(valid), .busy_o(busy), .overrun_o(overrun)
  );
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  initial forever begin
    @(negedge clk);
    if (valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: got valid at edge %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("left", left, e.l);
        check("right", right, e.r);
        check("latency_edge", cyc, e.e);
      end
      @(negedge clk);
      check("valid_width", valid, 0);
    end
  end
  task automatic fire(input int el, input int er);
    q.push_back('{el, er, cyc + 4});
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("busy_after_tick", busy, 1);
    step(3);
    check("idle_after_out", busy, 0);
  endtask
  task automatic mix(input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] g0,
                     input logic [3:0] g1, input logic st, input logic [1:0] pn,
                     input logic mu, input int el, input int er);
    data = {d1, d0};
    vld = 2'b11;
    gain = {g1, g0};
    stereo = st;
    pan = pn;
    mute = mu;
    step();
    vld = 2'b00;
    fire(el, er);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step();
  endtask
  initial begin
    step(2);
    check("rst_left", left, 0);
    check("rst_right", right, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    step();
    fire(0, 0);
    mix(8'hFF, 8'h80, 4'd8, 4'd8, 1'b0, 2'b00, 1'b0, 32512, 32512);
    mix(8'hFF, 8'hFF, 4'd8, 4'd8, 1'b0, 2'b00, 1'b0, 32767, 32767);
    mix(8'h00, 8'h00, 4'd8, 4'd8, 1'b0, 2'b00, 1'b0, -32768, -32768);
    mix(8'hC0, 8'h40, 4'd8, 4'd4, 1'b1, 2'b10, 1'b0, 16384, -8192);
    mix(8'hFF, 8'hFF, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 0, 0);
    mix(8'hFF, 8'hFF, 4'd8, 4'd8, 1'b0, 2'b00, 1'b1, 0, 0);
    mute = 1'b0;
    mix(8'h80, 8'h80, 4'd8, 4'd8, 1'b0, 2'b00, 1'b0, 0, 0);
    data = 16'h80FF;
    vld = 2'b01;
    q.push_back('{0, 0, cyc + 4});
    tick = 1'b1;
    step();
    tick = 1'b0;
    vld = 2'b00;
    step(3);
    fire(32512, 32512);
    check("no_overrun_min_spacing", overrun, 0);
    do_reset();
    q.push_back('{0, 0, cyc + 4});
    tick = 1'b1;
    step(2);
    tick = 1'b0;
    step(2);
    check("overrun_set", overrun, 1);
    fire(0, 0);
    check("overrun_sticky", overrun, 1);
    do_reset();
    check("overrun_cleared", overrun, 0);
    q.push_back('{0, 0, cyc + 4});
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(2);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(3);
    check("overrun_in_out", overrun, 1);
    check("out_tick_ignored", q.size(), 0);
    do_reset();
    mix(8'hFF, 8'h80, 4'd8, 4'd8, 1'b0, 2'b00, 1'b0, 32512, 32512);
    tick = 1'b1;
    step();
    tick = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_left", left, 0);
    check("midrst_right", right, 0);
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    step(5);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
